// File: rtl/comparador_pkg.sv
// Shared definitions for the LSB-first serial magnitude comparator.
// State encoding and counter width helper.
package comparador_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/comparador_serial_derizq_celda.sv
// Single-bit comparator cell: a differing bit overwrites g/l,
// an equal bit passes the incoming state through.
module celda_derizq (
  input  logic a_i,
  input  logic b_i,
  input  logic g_in,
  input  logic l_in,
  output logic g_out,
  output logic l_out
);

  logic diff;

  assign diff  = a_i ^ b_i;
  assign g_out = diff ? (a_i & ~b_i) : g_in;
  assign l_out = diff ? (~a_i & b_i) : l_in;

endmodule

// File: rtl/comparador_serial_derizq.sv
// Serial LSB-first unsigned comparator: one cell reused over N cycles,
// start/busy/done handshake, registered f (A>B) and eq (A==B).
module comparador_serial_derizq
  import comparador_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic         f,
  output logic         eq
);

  localparam int CW = cnt_w(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  sa_q, sa_d;
  logic [N-1:0]  sb_q, sb_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          g_q, g_d;
  logic          l_q, l_d;
  logic          f_q, f_d;
  logic          eq_q, eq_d;
  logic          done_q, done_d;
  logic          g_cell, l_cell;

  celda_derizq u_celda (
    .a_i   (sa_q[0]),
    .b_i   (sb_q[0]),
    .g_in  (g_q),
    .l_in  (l_q),
    .g_out (g_cell),
    .l_out (l_cell)
  );

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    cnt_d   = cnt_q;
    g_d     = g_q;
    l_d     = l_q;
    f_d     = f_q;
    eq_d    = eq_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          g_d     = 1'b0;
          l_d     = 1'b0;
          cnt_d   = '0;
          f_d     = 1'b0;
          eq_d    = 1'b0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        g_d   = g_cell;
        l_d   = l_cell;
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // last differing bit seen is the most significant one
        f_d     = g_q;
        eq_d    = ~g_q & ~l_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      cnt_q   <= '0;
      g_q     <= 1'b0;
      l_q     <= 1'b0;
      f_q     <= 1'b0;
      eq_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
      g_q     <= g_d;
      l_q     <= l_d;
      f_q     <= f_d;
      eq_q    <= eq_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == ST_SHIFT);
  assign done = done_q;
  assign f    = f_q;
  assign eq   = eq_q;

endmodule
